// File: rtl/pdp8_clkctl_pkg.sv
// pdp8_clkctl_pkg: shared encodings and helpers for the PDP-8 clock-control block.
//   - MODE_* : encodings of the 2-bit mode switch input
//   - S_*    : controller state encodings
//   - clkctl_tc()    : prescaler terminal count for a rate-select value
//   - mode_to_state(): steady-state controller state selected by a mode value
package pdp8_clkctl_pkg;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_STEP = 3'd2;
  localparam logic [2:0] S_HALT = 3'd3;
  localparam logic [2:0] S_FAST = 3'd4;

  // Terminal count (1 << 2*sel) - 1, saturated to div_w ones. Returned 64 bits wide;
  // the caller keeps the low div_w bits (div_w must be below 64).
  function automatic logic [63:0] clkctl_tc(input logic [31:0] sel, input int unsigned div_w);
    logic [31:0] shift;
    logic [63:0] ones;
    ones  = (64'd1 << div_w) - 64'd1;
    shift = {sel[30:0], 1'b0};
    if (sel == 32'd0) begin
      return 64'd0;
    end else if ((sel[31] == 1'b1) || (shift >= div_w)) begin
      return ones;
    end else begin
      return (64'd1 << shift) - 64'd1;
    end
  endfunction

  function automatic logic [2:0] mode_to_state(input logic [1:0] mode);
    logic [2:0] st;
    unique case (mode)
      MODE_RUN:  st = S_RUN;
      MODE_STEP: st = S_STEP;
      MODE_HALT: st = S_HALT;
      MODE_FAST: st = S_FAST;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/pdp8_clkctl_div.sv
// pdp8_clkctl_div: free-running prescaler with terminal-count compare.
// Ports:
//   clk      board clock
//   reset_n  synchronous active-low reset (counter to 0)
//   enable   count this cycle
//   clear    force counter to 0 (wins over enable)
//   tc       terminal count; compared with >= so a smaller tc acts immediately
//   tick     combinational, high in the cycle the counter is at/above tc while enabled
module pdp8_clkctl_div #(
  parameter int unsigned DIV_W = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] tc,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;

  assign tick = enable & (count_q >= tc);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pdp8_clkctl.sv
// pdp8_clkctl: clock-enable generator for the PDP-8 FPGA build (replaces the divided clock).
// Ports:
//   clk            board clock, all logic on its rising edge
//   reset_n        synchronous active-low block reset
//   sel            rate select (tc = (1 << 2*sel) - 1, saturated)
//   mode           00 run, 01 single-step, 10 halt, 11 full speed
//   step_req       one-cycle step request (step mode only)
//   cpu_reset_req  one-cycle request to start a stretched CPU reset
//   ce             registered one-cycle clock enable for cpu/io/ram
//   cpu_reset      active-high reset to cpu/io/ram, held across RST_CYC forced ce pulses
//   step_pend      a step request is waiting for its ce
//   ce_count       ce pulses issued; a live counter only when PDP8_CLKCTL_PERF_EN is
//                  defined, otherwise tied to 0
module pdp8_clkctl
  import pdp8_clkctl_pkg::*;
#(
  parameter int unsigned DIV_W   = 25,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned RST_CYC = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SEL_W-1:0] sel,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic             cpu_reset_req,
  output logic             ce,
  output logic             cpu_reset,
  output logic             step_pend,
  output logic [31:0]      ce_count
);

  localparam int unsigned RstCntW = $clog2(RST_CYC + 1);

  logic [2:0]         state_q, state_d;
  logic [RstCntW-1:0] rst_cnt_q, rst_cnt_d;
  logic               ce_q, ce_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               step_pend_q, step_pend_d;
  logic [2:0]         mode_st;
  logic               tick;
  logic               div_en;
  logic [63:0]        tc_full;
  logic [DIV_W-1:0]   tc;
  logic               unused_tc_hi;

  assign tc_full      = clkctl_tc(32'(sel), DIV_W);
  assign tc           = tc_full[DIV_W-1:0];
  assign unused_tc_hi = ^tc_full[63:DIV_W];

  // Prescaler only counts in rate-limited states; elsewhere it is held at 0.
  assign div_en = (state_q == S_RUN) || (state_q == S_STEP);

  pdp8_clkctl_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (div_en),
    .clear  (!div_en),
    .tc     (tc),
    .tick   (tick)
  );

  assign mode_st = mode_to_state(mode);

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    ce_d        = 1'b0;
    cpu_reset_d = 1'b0;
    step_pend_d = 1'b0;
    case (state_q)
      S_RST: begin
        // cpu_reset stays high for the last forced pulse and drops on the next cycle.
        ce_d        = 1'b1;
        cpu_reset_d = 1'b1;
        rst_cnt_d   = rst_cnt_q + RstCntW'(1);
        if (rst_cnt_q == RstCntW'(RST_CYC - 1)) begin
          state_d = mode_st;
        end
      end
      S_RUN: begin
        ce_d    = tick;
        state_d = mode_st;
      end
      S_STEP: begin
        ce_d    = step_pend_q & tick;
        state_d = mode_st;
        // A request landing on the consuming tick re-arms the pend.
        if (mode_st == S_STEP) begin
          step_pend_d = step_req | (step_pend_q & ~tick);
        end
      end
      S_HALT: begin
        state_d = mode_st;
      end
      S_FAST: begin
        ce_d    = 1'b1;
        state_d = mode_st;
      end
      default: begin
        state_d     = S_RST;
        rst_cnt_d   = '0;
        cpu_reset_d = 1'b1;
      end
    endcase
    if (cpu_reset_req) begin
      state_d     = S_RST;
      rst_cnt_d   = '0;
      cpu_reset_d = 1'b1;
      step_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_RST;
      rst_cnt_q   <= '0;
      ce_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      ce_q        <= ce_d;
      cpu_reset_q <= cpu_reset_d;
      step_pend_q <= step_pend_d;
    end
  end

  assign ce        = ce_q;
  assign cpu_reset = cpu_reset_q;
  assign step_pend = step_pend_q;

`ifdef PDP8_CLKCTL_PERF_EN
  logic [31:0] ce_count_q;

  // Counts alongside ce_q so ce_count already includes the pulse now on ce.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ce_count_q <= '0;
    end else begin
      ce_count_q <= ce_count_q + 32'(ce_d);
    end
  end

  assign ce_count = ce_count_q;
`else
  assign ce_count = '0;
`endif

endmodule

// File: tb/tb_pdp8_clkctl.sv
// Self-checking bench for pdp8_clkctl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the clock controller.
module tb_pdp8_clkctl;

`ifdef PDP8_CLKCTL_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [1:0]  mode = 2'b00;
  logic        step_req = 1'b0;
  logic        cpu_reset_req = 1'b0;
  logic        ce;
  logic        cpu_reset;
  logic        step_pend;
  logic [31:0] ce_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pdp8_clkctl #(
    .DIV_W  (25),
    .SEL_W  (4),
    .RST_CYC(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sel          (sel),
    .mode         (mode),
    .step_req     (step_req),
    .cpu_reset_req(cpu_reset_req),
    .ce           (ce),
    .cpu_reset    (cpu_reset),
    .step_pend    (step_pend),
    .ce_count     (ce_count)
  );

  // Behavioural model: "resetting" with a number of forced pulses left, otherwise the
  // effective mode; prescaler value as a plain integer.
  bit          m_resetting = 1'b1;
  int          m_rst_left  = 16;
  int          m_mode      = 0;
  longint      m_presc     = 0;
  bit          m_pend      = 1'b0;
  bit          e_ce        = 1'b0;
  bit          e_rst       = 1'b1;
  bit [31:0]   e_cnt       = 32'd0;

  function automatic longint model_tc(int s);
    if (s == 0) return 0;
    if (2 * s >= 25) return (longint'(1) << 25) - 1;
    return (longint'(1) << (2 * s)) - 1;
  endfunction

  function automatic void model_step();
    bit     was_rst;
    int     old_mode;
    bit     active;
    bit     tk;
    if (!reset_n) begin
      m_resetting = 1'b1;
      m_rst_left  = 16;
      m_presc     = 0;
      m_pend      = 1'b0;
      e_ce        = 1'b0;
      e_rst       = 1'b1;
      e_cnt       = 32'd0;
      return;
    end
    was_rst  = m_resetting;
    old_mode = m_mode;
    active   = !was_rst && (old_mode == 0 || old_mode == 1);
    tk       = active && (m_presc >= model_tc(int'(sel)));
    if (was_rst) e_ce = 1'b1;
    else if (old_mode == 0) e_ce = tk;
    else if (old_mode == 1) e_ce = m_pend && tk;
    else if (old_mode == 2) e_ce = 1'b0;
    else e_ce = 1'b1;
    e_rst   = was_rst || cpu_reset_req;
    m_presc = active ? (tk ? 0 : m_presc + 1) : 0;
    if (cpu_reset_req) begin
      m_resetting = 1'b1;
      m_rst_left  = 16;
      m_pend      = 1'b0;
    end else if (was_rst) begin
      m_rst_left = m_rst_left - 1;
      m_pend     = 1'b0;
      if (m_rst_left == 0) begin
        m_resetting = 1'b0;
        m_mode      = int'(mode);
      end
    end else begin
      m_pend = (old_mode == 1 && mode == 2'b01) ? (step_req || (m_pend && !tk)) : 1'b0;
      m_mode = int'(mode);
    end
    e_cnt = e_cnt + 32'(e_ce);
  endfunction

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic clk_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mode = 2'b00; sel = 4'd0; step_req = 1'b0; cpu_reset_req = 1'b0;
    repeat (3) clk_step();
    n_checks++;
    if (ce !== 1'b0 || cpu_reset !== 1'b1 || step_pend !== 1'b0 || ce_count !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_state: ce=%b cpu_reset=%b step_pend=%b ce_count=%0d want 0 1 0 0",
               ce, cpu_reset, step_pend, ce_count);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      clk_step();
      n_checks++;
      if (ce !== 1'b1 || cpu_reset !== 1'b1) begin
        n_errors++;
        $display("FAIL forced_pulse %0d: ce=%b cpu_reset=%b want 1 1", i, ce, cpu_reset);
      end
    end
    for (int i = 0; i < 4; i++) begin
      clk_step();
      n_checks++;
      if (ce !== 1'b1 || cpu_reset !== 1'b0) begin
        n_errors++;
        $display("FAIL post_reset_run %0d: ce=%b cpu_reset=%b want 1 0", i, ce, cpu_reset);
      end
    end
  endtask

  task automatic test_run_rate();
    int gap;
    int waited;
    mode = 2'b00; sel = 4'd1;
    gap = 0;
    do begin clk_step(); gap++; end while (ce !== 1'b1 && gap < 20);
    for (int p = 0; p < 3; p++) begin
      gap = 0;
      do begin clk_step(); gap++; end while (ce !== 1'b1 && gap < 20);
      n_checks++;
      if (gap != 4) begin
        n_errors++;
        $display("FAIL run_period sel1 #%0d: gap=%0d want 4", p, gap);
      end
    end
    sel = 4'd3;
    waited = 0;
    while (m_presc != 40 && waited < 200) begin clk_step(); waited++; end
    n_checks++;
    if (m_presc != 40) begin
      n_errors++;
      $display("FAIL presc_reach_40: waited=%0d cycles without reaching 40", waited);
    end
    sel = 4'd1;
    clk_step();
    n_checks++;
    if (ce !== 1'b1) begin
      n_errors++;
      $display("FAIL sel_fast_switch: ce=%b want 1", ce);
    end
    gap = 0;
    do begin clk_step(); gap++; end while (ce !== 1'b1 && gap < 20);
    n_checks++;
    if (gap != 4) begin
      n_errors++;
      $display("FAIL period_after_switch: gap=%0d want 4", gap);
    end
  endtask

  task automatic test_step();
    int n_ce;
    int waited;
    mode = 2'b01; sel = 4'd1;
    clk_step(); clk_step();
    waited = 0;
    while (m_presc != 0 && waited < 20) begin clk_step(); waited++; end
    step_req = 1'b1; clk_step();
    step_req = 1'b0; clk_step();
    step_req = 1'b1; clk_step();
    step_req = 1'b0;
    n_checks++;
    if (step_pend !== 1'b1) begin
      n_errors++;
      $display("FAIL step_pend_set: step_pend=%b want 1", step_pend);
    end
    n_ce = (ce === 1'b1) ? 1 : 0;
    repeat (8) begin clk_step(); if (ce === 1'b1) n_ce++; end
    n_checks++;
    if (n_ce != 1 || step_pend !== 1'b0) begin
      n_errors++;
      $display("FAIL step_coalesce: ce_pulses=%0d step_pend=%b want 1 0", n_ce, step_pend);
    end
    step_req = 1'b1; clk_step();
    step_req = 1'b0;
    n_checks++;
    if (step_pend !== 1'b1) begin
      n_errors++;
      $display("FAIL step_third_pend: step_pend=%b want 1", step_pend);
    end
    n_ce = 0;
    repeat (8) begin clk_step(); if (ce === 1'b1) n_ce++; end
    n_checks++;
    if (n_ce != 1 || step_pend !== 1'b0) begin
      n_errors++;
      $display("FAIL step_third: ce_pulses=%0d step_pend=%b want 1 0", n_ce, step_pend);
    end
  endtask

  task automatic test_halt();
    int bad;
    int lat;
    mode = 2'b10;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step_req = 1'($urandom_range(0, 1));
      clk_step();
      n_checks++;
      if (ce !== 1'b0 || step_pend !== 1'b0) begin
        n_errors++;
        bad++;
        if (bad < 5) $display("FAIL halt_quiet %0d: ce=%b step_pend=%b want 0 0", i, ce,
                              step_pend);
      end
    end
    step_req = 1'b0; mode = 2'b00; sel = 4'd1;
    lat = 0;
    do begin clk_step(); lat++; end while (ce !== 1'b1 && lat < 5);
    n_checks++;
    if (ce !== 1'b1) begin
      n_errors++;
      $display("FAIL halt_resume: no ce within %0d cycles, want <= 5", lat);
    end
  endtask

  task automatic test_reset_restart();
    mode = 2'b00; sel = 4'd0;
    cpu_reset_req = 1'b1; clk_step();
    cpu_reset_req = 1'b0;
    repeat (10) clk_step();
    cpu_reset_req = 1'b1; clk_step();
    cpu_reset_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      clk_step();
      n_checks++;
      if (ce !== 1'b1 || cpu_reset !== 1'b1) begin
        n_errors++;
        $display("FAIL restart_pulse %0d: ce=%b cpu_reset=%b want 1 1", i, ce, cpu_reset);
      end
    end
    clk_step();
    n_checks++;
    if (cpu_reset !== 1'b0) begin
      n_errors++;
      $display("FAIL restart_release: cpu_reset=%b want 0", cpu_reset);
    end
  endtask

  task automatic test_random();
    int bad;
    bit [31:0] want_cnt;
    bad = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) sel = 4'($urandom_range(0, 2));
      step_req      = ($urandom_range(0, 3) == 0);
      cpu_reset_req = ($urandom_range(0, 79) == 0);
      reset_n       = ($urandom_range(0, 399) != 0);
      clk_step();
      want_cnt = PerfEn ? e_cnt : 32'd0;
      n_checks++;
      if (ce !== e_ce || cpu_reset !== e_rst || step_pend !== m_pend || ce_count !== want_cnt)
      begin
        n_errors++;
        bad++;
        if (bad < 8)
          $display("FAIL random cyc %0d: ce=%b rst=%b pend=%b cnt=%0d want %b %b %b %0d", i,
                   ce, cpu_reset, step_pend, ce_count, e_ce, e_rst, m_pend, want_cnt);
      end
    end
    step_req = 1'b0; cpu_reset_req = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_perf();
    reset_n = 1'b0; mode = 2'b00; sel = 4'd0;
    repeat (2) clk_step();
    reset_n = 1'b1;
    repeat (116) clk_step();
    n_checks++;
    if (ce_count !== (PerfEn ? 32'd116 : 32'd0)) begin
      n_errors++;
      $display("FAIL perf_count: ce_count=%0d want %0d", ce_count, PerfEn ? 116 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_run_rate();
    test_step();
    test_halt();
    test_reset_restart();
    test_random();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
